// File: rtl/reg_select_pipe_decoder_pkg.sv
// Shared types and defaults for the pipelined register-select decoder.
package reg_select_pipe_decoder_pkg;

    localparam int unsigned WB_DEPTH_DEFAULT = 3;

    // Stage address field is sized for the widest supported ADDR_W; narrower
    // addresses are zero-extended so one struct serves every parameterisation.
    localparam int unsigned RD_W_MAX = 16;

    typedef struct packed {
        logic [RD_W_MAX-1:0] rd;
        logic                wr;
        logic                valid;
    } stage_t;

    // True when a stage carries a write that will really land in the register file.
    function automatic logic stage_writes(stage_t s, logic zero_suppress);
        return s.valid & s.wr & ~(zero_suppress & (s.rd == '0));
    endfunction

endpackage

// File: rtl/reg_select_pipe_decoder_onehot_dec.sv
// onehot_dec: binary address to one-hot select, gated by an enable.
module reg_select_pipe_decoder_onehot_dec #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // Full-width constant 1 so the shift never truncates.
    always_comb begin
        onehot = en ? (NUM_REGS'(1) << addr) : '0;
    end

endmodule

// File: rtl/reg_select_pipe_decoder.sv
// Pipelined register-select decoder: registered A/B read selects, D write
// select delayed WB_DEPTH unstalled cycles, and RAW hazard flags.
module reg_select_pipe_decoder
    import reg_select_pipe_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned NUM_REGS      = 2 ** ADDR_W,
    parameter int unsigned WB_DEPTH      = WB_DEPTH_DEFAULT,
    parameter bit          ZERO_SUPPRESS = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   rs_in,
    input  logic [ADDR_W-1:0]   rt_in,
    input  logic [ADDR_W-1:0]   rd_in,
    input  logic                wr_en_in,
    input  logic                stall,
    input  logic                flush,
    output logic [NUM_REGS-1:0] a_sel,
    output logic [NUM_REGS-1:0] b_sel,
    output logic [NUM_REGS-1:0] d_sel,
    output logic                d_valid,
    output logic                a_hazard,
    output logic                b_hazard
);

    stage_t                stage_q [0:WB_DEPTH];
    logic [NUM_REGS-1:0]   a_dec;
    logic [NUM_REGS-1:0]   b_dec;
    logic [WB_DEPTH-1:0]   a_match;
    logic [WB_DEPTH-1:0]   b_match;
    logic [RD_W_MAX-1:0]   rs_ext;
    logic [RD_W_MAX-1:0]   rt_ext;
    logic [RD_W_MAX-1:0]   rd_ext;
    logic                  advance;
    logic                  accept;

    assign rs_ext = RD_W_MAX'(rs_in);
    assign rt_ext = RD_W_MAX'(rt_in);
    assign rd_ext = RD_W_MAX'(rd_in);

    // Flush overrides stall so older writes keep draining while stage 0 is killed.
    assign advance = flush | ~stall;
    assign accept  = ~flush & ~stall & in_valid;

    reg_select_pipe_decoder_onehot_dec #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec_a (
        .addr   (rs_in),
        .en     (1'b1),
        .onehot (a_dec)
    );

    reg_select_pipe_decoder_onehot_dec #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec_b (
        .addr   (rt_in),
        .en     (1'b1),
        .onehot (b_dec)
    );

    // Only the writeback stage is decoded; earlier stages stay encoded.
    assign d_valid = stage_writes(stage_q[WB_DEPTH], ZERO_SUPPRESS);

    reg_select_pipe_decoder_onehot_dec #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec_d (
        .addr   (stage_q[WB_DEPTH].rd[ADDR_W-1:0]),
        .en     (d_valid),
        .onehot (d_sel)
    );

    // Writeback stage is excluded: the register file writes before it reads.
    for (genvar g = 0; g < WB_DEPTH; g++) begin : g_hazard
        assign a_match[g] = stage_writes(stage_q[g], ZERO_SUPPRESS) && (stage_q[g].rd == rs_ext);
        assign b_match[g] = stage_writes(stage_q[g], ZERO_SUPPRESS) && (stage_q[g].rd == rt_ext);
    end

    // Pipeline registers: accept into stage 0, shift the rest, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sel    <= '0;
            b_sel    <= '0;
            a_hazard <= 1'b0;
            b_hazard <= 1'b0;
            for (int i = 0; i <= WB_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 1; i <= WB_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            if (accept) begin
                a_sel      <= a_dec;
                b_sel      <= b_dec;
                a_hazard   <= |a_match;
                b_hazard   <= |b_match;
                stage_q[0] <= '{rd: rd_ext, wr: wr_en_in, valid: 1'b1};
            end else begin
                a_sel      <= '0;
                b_sel      <= '0;
                a_hazard   <= 1'b0;
                b_hazard   <= 1'b0;
                stage_q[0] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_select_pipe_decoder.sv
// Self-checking bench for reg_select_pipe_decoder with an age-based reference model.
module tb_reg_select_pipe_decoder;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned WB       = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [ADDR_W-1:0]   rs_in = '0;
    logic [ADDR_W-1:0]   rt_in = '0;
    logic [ADDR_W-1:0]   rd_in = '0;
    logic                wr_en_in = 1'b0;
    logic                stall = 1'b0;
    logic                flush = 1'b0;
    logic [NUM_REGS-1:0] a_sel, b_sel, d_sel;
    logic                d_valid, a_hazard, b_hazard;

    int errors = 0;
    int checks = 0;

    reg_select_pipe_decoder #(
        .ADDR_W        (ADDR_W),
        .WB_DEPTH      (WB),
        .ZERO_SUPPRESS (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .rs_in    (rs_in),
        .rt_in    (rt_in),
        .rd_in    (rd_in),
        .wr_en_in (wr_en_in),
        .stall    (stall),
        .flush    (flush),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .d_sel    (d_sel),
        .d_valid  (d_valid),
        .a_hazard (a_hazard),
        .b_hazard (b_hazard)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight instructions tagged with unstalled edges since acceptance.
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic              wr;
        int                age;
    } ent_t;

    ent_t                q[$];
    logic [NUM_REGS-1:0] exp_a = '0, exp_b = '0, exp_d = '0;
    logic                exp_dv = 1'b0, exp_ah = 1'b0, exp_bh = 1'b0;

    function automatic logic lands(ent_t e);
        return e.wr && (e.rd != 0);
    endfunction

    task automatic model_reset();
        q.delete();
        exp_a = '0; exp_b = '0; exp_d = '0;
        exp_dv = 1'b0; exp_ah = 1'b0; exp_bh = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [ADDR_W-1:0] rs, rt, rd,
                              input logic wr, st, fl);
        ent_t nq[$];
        logic ah, bh;
        if (st && !fl) return;
        ah = 1'b0; bh = 1'b0;
        foreach (q[i]) begin
            if (q[i].age < WB && lands(q[i])) begin
                if (q[i].rd == rs) ah = 1'b1;
                if (q[i].rd == rt) bh = 1'b1;
            end
        end
        foreach (q[i]) begin
            ent_t e;
            e = q[i];
            e.age++;
            if (e.age <= WB) nq.push_back(e);
        end
        q = nq;
        if (fl || !v) begin
            exp_a = '0; exp_b = '0; exp_ah = 1'b0; exp_bh = 1'b0;
        end else begin
            q.push_back('{rd: rd, wr: wr, age: 0});
            exp_a = 32'd1 << rs;
            exp_b = 32'd1 << rt;
            exp_ah = ah;
            exp_bh = bh;
        end
        exp_d = '0; exp_dv = 1'b0;
        foreach (q[i]) begin
            if (q[i].age == WB && lands(q[i])) begin
                exp_d = 32'd1 << q[i].rd;
                exp_dv = 1'b1;
            end
        end
    endtask

    // One clock: drive between edges, update model at the edge, return just after it.
    task automatic step(input logic v, input logic [ADDR_W-1:0] rs, rt, rd,
                        input logic wr, st, fl);
        @(negedge clk);
        in_valid = v; rs_in = rs; rt_in = rt; rd_in = rd; wr_en_in = wr; stall = st; flush = fl;
        @(posedge clk);
        model_edge(v, rs, rt, rd, wr, st, fl);
        #1;
    endtask

    task automatic bubble();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_sel, b_sel, d_sel, d_valid, a_hazard, b_hazard} !== '0) begin
            errors++;
            $display("FAIL reset_initial: a=%h b=%h d=%h dv=%b ah=%b bh=%b, want all zero",
                     a_sel, b_sel, d_sel, d_valid, a_hazard, b_hazard);
        end
        rst_n = 1'b1;
        model_reset();
        // Mid-stream async reset between edges.
        step(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({a_sel, b_sel, d_sel, d_valid, a_hazard, b_hazard} !== '0) begin
            errors++;
            $display("FAIL reset_async: a=%h b=%h d=%h dv=%b ah=%b bh=%b, want all zero",
                     a_sel, b_sel, d_sel, d_valid, a_hazard, b_hazard);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bubble();
            checks++;
            if (d_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_drain cyc%0d: d_valid=%b want 0", i, d_valid);
            end
        end
    endtask

    task automatic test_basic_latency();
        step(1'b1, 5'd3, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0);
        checks++;
        if (a_sel !== 32'h8 || b_sel !== 32'h80) begin
            errors++;
            $display("FAIL basic_ab: a=%h b=%h want 00000008 00000080", a_sel, b_sel);
        end
        for (int i = 1; i <= 4; i++) begin
            bubble();
            checks++;
            if (d_sel !== ((i == 3) ? 32'h200 : 32'h0) || d_valid !== (i == 3)) begin
                errors++;
                $display("FAIL basic_d cyc%0d: d=%h dv=%b want %h %b", i, d_sel, d_valid,
                         (i == 3) ? 32'h200 : 32'h0, (i == 3));
            end
        end
    endtask

    task automatic test_hazard();
        step(1'b1, 5'd10, 5'd11, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_hazard !== 1'b1 || b_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_rd5: ah=%b bh=%b want 1 0", a_hazard, b_hazard);
        end
        for (int i = 0; i < 4; i++) bubble();
        step(1'b1, 5'd10, 5'd11, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd6, 5'd13, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_hazard !== 1'b0 || b_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_rd0: ah=%b bh=%b want 0 0", a_hazard, b_hazard);
        end
        for (int i = 0; i < 4; i++) begin
            bubble();
            checks++;
            if (d_sel !== 32'h0 || d_valid !== 1'b0) begin
                errors++;
                $display("FAIL hazard_rd0_d cyc%0d: d=%h dv=%b want 0 0", i, d_sel, d_valid);
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 5'd2, 5'd3, 5'd12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'($urandom_range(0, 31)), 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (a_sel !== 32'h4 || d_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: a=%h dv=%b want 00000004 0", i, a_sel, d_valid);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            bubble();
            checks++;
            if (d_sel !== ((i == 3) ? 32'h1000 : 32'h0)) begin
                errors++;
                $display("FAIL stall_d cyc%0d: d=%h want %h", i, d_sel,
                         (i == 3) ? 32'h1000 : 32'h0);
            end
        end
        bubble();
    endtask

    task automatic test_flush_stall();
        logic seen8;
        seen8 = 1'b0;
        step(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd9, 5'd9, 5'd8, 1'b1, 1'b1, 1'b1);
        checks++;
        if (a_sel !== 32'h0 || b_sel !== 32'h0) begin
            errors++;
            $display("FAIL flush_ab: a=%h b=%h want 0 0", a_sel, b_sel);
        end
        for (int i = 1; i <= 4; i++) begin
            bubble();
            if (d_sel === 32'h100) seen8 = 1'b1;
            if (i == 2) begin
                checks++;
                if (d_sel !== 32'h10) begin
                    errors++;
                    $display("FAIL flush_d4: d=%h want 00000010", d_sel);
                end
            end
        end
        checks++;
        if (seen8 !== 1'b0) begin
            errors++;
            $display("FAIL flush_killed: rd8 write seen=%b want 0", seen8);
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_REGS-1:0] want;
        step(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            bubble();
            want = 32'd1 << i;
            checks++;
            if (d_sel !== want || d_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b cyc%0d: d=%h dv=%b want %h 1", i, d_sel, d_valid, want);
            end
        end
        bubble();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            checks++;
            if ({a_sel, b_sel, d_sel, d_valid, a_hazard, b_hazard} !==
                {exp_a, exp_b, exp_d, exp_dv, exp_ah, exp_bh}) begin
                errors++;
                $display("FAIL random n=%0d: a=%h b=%h d=%h dv=%b ah=%b bh=%b, want a=%h b=%h d=%h dv=%b ah=%b bh=%b",
                         n, a_sel, b_sel, d_sel, d_valid, a_hazard, b_hazard,
                         exp_a, exp_b, exp_d, exp_dv, exp_ah, exp_bh);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_hazard();
        test_stall();
        test_flush_stall();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
